fir_mac_seq: RTL and testbench

Sequencer for the single shared FIR multiply-accumulate PE. It clears the data buffer, accepts input samples over a valid/ready stream, and writes each sample into a circular data RAM. It then walks the taps, generating tap/data RAM addresses and the PE's cal/acc_on/last controls, and presents each filtered output on a valid/ready stream. It sits between the AXI-Stream front end, the tap and data BRAMs (1-cycle read latency), and the PE.

---
 rtl/fir_mac_seq_pkg.sv | 16 +
 rtl/fir_circ_idx.sv | 48 ++++
 rtl/fir_mac_seq.sv | 166 ++++++++++++++++
 tb/tb_fir_mac_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_seq_pkg.sv
// Shared types for the FIR MAC sequencer.
// State encoding and the tap-count floor.
package fir_mac_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_IN,
        S_MAC,
        S_OUT,
        S_DONE
    } state_e;

    localparam int MIN_TAP = 2;

endpackage

// File: rtl/fir_circ_idx.sv
// Modulo-T circular index with clear/increment.
// Also gives (idx - k) mod T for reading back through history.
module fir_circ_idx
    import fir_mac_seq_pkg::*;
#(
    parameter int pIDX_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [pIDX_W-1:0] mod_i,
    input  logic [pIDX_W-1:0] k_i,
    output logic [pIDX_W-1:0] idx_o,
    output logic [pIDX_W-1:0] sub_o
);

    logic [pIDX_W-1:0] idx_q;
    logic [pIDX_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            if (idx_q == mod_i - pIDX_W'(1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + pIDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

    // Wrap by T, not 2^W; the add may overflow W bits but the result is < T.
    assign sub_o = (idx_q >= k_i) ? (idx_q - k_i)
                                  : (idx_q + mod_i - k_i);

endmodule

// File: rtl/fir_mac_seq.sv
// Sequencer for the shared FIR MAC PE: clears the data buffer,
// writes samples circularly, walks taps and hands results out.
module fir_mac_seq
    import fir_mac_seq_pkg::*;
#(
    parameter int pMAX_TAP = 11,
    parameter int pIDX_W   = 4,
    parameter int pLEN_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ap_start,
    input  logic [pIDX_W-1:0] tap_num,
    input  logic [pLEN_W-1:0] data_length,
    output logic              ap_idle,
    output logic              ap_done,
    input  logic              ss_tvalid,
    output logic              ss_tready,
    output logic              sm_tvalid,
    input  logic              sm_tready,
    output logic              sm_tlast,
    output logic [pIDX_W-1:0] tap_addr,
    output logic [pIDX_W-1:0] data_addr,
    output logic              data_we,
    output logic              data_wsel,
    output logic              pe_cal,
    output logic              pe_acc_on,
    output logic              pe_last
);

    state_e            state_q;
    logic [pIDX_W-1:0] t_q;
    logic [pIDX_W-1:0] k_q;
    logic [pLEN_W-1:0] l_q;
    logic [pLEN_W-1:0] cnt_q;
    logic              pe_cal_q;
    logic              pe_acc_q;

    logic [pIDX_W-1:0] wptr;
    logic [pIDX_W-1:0] rd_idx;
    logic              k_last;
    logic              s_last;
    logic              start;
    logic              out_hs;

    assign k_last = (k_q == t_q - pIDX_W'(1));
    assign s_last = (cnt_q == l_q - pLEN_W'(1));
    assign start  = (state_q == S_IDLE) && ap_start;
    assign out_hs = (state_q == S_OUT) && sm_tready;

    fir_circ_idx #(
        .pIDX_W (pIDX_W)
    ) u_wptr (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (start),
        .inc_i  (out_hs),
        .mod_i  (t_q),
        .k_i    (k_q),
        .idx_o  (wptr),
        .sub_o  (rd_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            k_q      <= '0;
            l_q      <= '0;
            cnt_q    <= '0;
            pe_cal_q <= 1'b0;
            pe_acc_q <= 1'b0;
        end else begin
            // PE controls trail the addresses by the RAM read latency.
            pe_cal_q <= (state_q == S_MAC) && !k_last;
            pe_acc_q <= (state_q == S_MAC) && (k_q != '0);
            unique case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        t_q     <= tap_num;
                        l_q     <= data_length;
                        k_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (k_last) begin
                        k_q     <= '0;
                        state_q <= (l_q == '0) ? S_DONE : S_WAIT_IN;
                    end else begin
                        k_q <= k_q + pIDX_W'(1);
                    end
                end
                S_WAIT_IN: begin
                    if (ss_tvalid) begin
                        k_q     <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (k_last) begin
                        state_q <= S_OUT;
                    end else begin
                        k_q <= k_q + pIDX_W'(1);
                    end
                end
                S_OUT: begin
                    if (sm_tready) begin
                        cnt_q   <= cnt_q + pLEN_W'(1);
                        state_q <= s_last ? S_DONE : S_WAIT_IN;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        tap_addr  = '0;
        data_addr = '0;
        data_we   = 1'b0;
        data_wsel = 1'b0;
        pe_last   = 1'b0;
        unique case (state_q)
            S_IDLE: ap_idle = 1'b1;
            S_CLEAR: begin
                data_we   = 1'b1;
                data_addr = k_q;
            end
            S_WAIT_IN: begin
                ss_tready = 1'b1;
                data_addr = wptr;
                data_we   = ss_tvalid;
                data_wsel = ss_tvalid;
            end
            S_MAC: begin
                tap_addr  = k_q;
                data_addr = rd_idx;
            end
            S_OUT: begin
                tap_addr  = k_q;
                data_addr = rd_idx;
                pe_last   = 1'b1;
                sm_tvalid = 1'b1;
                sm_tlast  = s_last;
            end
            S_DONE: ap_done = 1'b1;
            default: ;
        endcase
    end

    assign pe_cal    = pe_cal_q;
    assign pe_acc_on = pe_acc_q;

    a_tap_range: assert property (@(posedge clk) disable iff (!rst_n)
        start |-> (int'(tap_num) >= MIN_TAP &&
                   int'(tap_num) <= pMAX_TAP));

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq with RAM/PE models and a
// convolution scoreboard on the output stream.
module tb_fir_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic [3:0]  tap_num = '0;
    logic [31:0] data_length = '0;
    logic        ap_idle, ap_done;
    logic        ss_tvalid = 1'b0;
    logic        ss_tready;
    logic        sm_tvalid;
    logic        sm_tready = 1'b0;
    logic        sm_tlast;
    logic [3:0]  tap_addr, data_addr;
    logic        data_we, data_wsel;
    logic        pe_cal, pe_acc_on, pe_last;

    int ss_tdata = 0;
    int taps[16];
    int dmem[16];
    int tap_rd = 0, dat_rd = 0, acc = 0, pe_y;
    int cyc = 0;

    int n_tests = 0, n_fail = 0;
    int exp_y[$];
    bit exp_last[$];
    int hist[$];
    int out_cyc[$];
    int job_t = 0, job_l = 0, sidx = 0;

    fir_mac_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ap_start    (ap_start),
        .tap_num     (tap_num),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .ss_tvalid   (ss_tvalid),
        .ss_tready   (ss_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tready   (sm_tready),
        .sm_tlast    (sm_tlast),
        .tap_addr    (tap_addr),
        .data_addr   (data_addr),
        .data_we     (data_we),
        .data_wsel   (data_wsel),
        .pe_cal      (pe_cal),
        .pe_acc_on   (pe_acc_on),
        .pe_last     (pe_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tap_rd <= taps[tap_addr];
        dat_rd <= dmem[data_addr];
        if (data_we) dmem[data_addr] <= data_wsel ? ss_tdata : 0;
        if (pe_cal) acc <= pe_acc_on ? acc + tap_rd * dat_rd
                                     : tap_rd * dat_rd;
    end

    always_comb pe_y = acc + tap_rd * dat_rd;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (rst_n && sm_tvalid && sm_tready) begin
            chk("sb_pop", exp_y.size() > 0, 1);
            chk("out_pe_last", pe_last, 1);
            if (exp_y.size() > 0) begin
                chk("out_y", pe_y, exp_y.pop_front());
                chk("out_tlast", sm_tlast, exp_last.pop_front());
            end
            out_cyc.push_back(cyc);
        end
    end

    task automatic start_job(input int t, input int l);
        @(negedge clk);
        tap_num = 4'(t);
        data_length = 32'(l);
        ap_start = 1'b1;
        hist.delete();
        job_t = t;
        job_l = l;
        sidx = 0;
        @(negedge clk);
        ap_start = 1'b0;
    endtask

    task automatic send(input int x);
        int n = 0;
        int y = 0;
        ss_tdata = x;
        ss_tvalid = 1'b1;
        while (!ss_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ss_timeout", n, 0);
        hist.push_front(x);
        for (int k = 0; k < job_t && k < hist.size(); k++)
            y += taps[k] * hist[k];
        exp_y.push_back(y);
        exp_last.push_back(sidx == job_l - 1);
        sidx++;
        @(negedge clk);
        ss_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!ap_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", ap_done, 1);
        @(negedge clk);
    endtask

    initial begin
        int h_ta, h_da, h_y, n;
        int ea[4], et[4], ec[4], eo[4];
        ea = '{1, 0, 2, 2};
        et = '{0, 1, 2, 2};
        ec = '{0, 1, 1, 0};
        eo = '{0, 0, 1, 1};
        foreach (taps[i]) taps[i] = 0;
        foreach (dmem[i]) dmem[i] = 99;

        repeat (2) @(negedge clk);
        chk("rst_idle", {ap_idle, ap_done, ss_tready, sm_tvalid},
            4'b1000);
        chk("rst_ctl", {data_we, pe_cal, pe_acc_on, pe_last,
                        tap_addr, data_addr}, 0);
        rst_n = 1'b1;

        // T=11, L=0: clear only
        start_job(11, 0);
        for (int c = 0; c < 11; c++) begin
            chk($sformatf("clr%0d", c),
                {data_we, data_wsel, data_addr}, {1'b1, 1'b0, 4'(c)});
            chk("clr_nov", sm_tvalid, 0);
            @(negedge clk);
        end
        chk("l0_done", ap_done, 1);
        @(negedge clk);
        chk("l0_idle", ap_idle, 1);

        // T=3, L=4, unit inputs
        taps[0] = 1; taps[1] = 2; taps[2] = 3;
        sm_tready = 1'b1;
        out_cyc.delete();
        start_job(3, 4);
        send(1);
        send(1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mac%0d", i),
                {tap_addr, data_addr, pe_cal, pe_acc_on},
                {4'(et[i]), 4'(ea[i]), 1'(ec[i]), 1'(eo[i])});
            if (i < 3) @(negedge clk);
        end
        send(1);
        send(1);
        wait_done();
        chk("tput_n", out_cyc.size(), 4);
        for (int i = 1; i < out_cyc.size(); i++)
            chk("tput", out_cyc[i] - out_cyc[i-1], 5);

        // backpressure, idle input, ignored tvalid
        taps[0] = 2; taps[1] = 5; taps[2] = 7;
        sm_tready = 1'b0;
        start_job(3, 2);
        send(3);
        n = 0;
        while (!sm_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", sm_tvalid, 1);
        h_ta = int'(tap_addr);
        h_da = int'(data_addr);
        h_y = pe_y;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {sm_tvalid, pe_cal, tap_addr, data_addr},
                {1'b1, 1'b0, 4'(h_ta), 4'(h_da)});
            chk("bp_y", pe_y, h_y);
        end
        sm_tready = 1'b1;
        @(negedge clk);
        chk("wptr_adv", {ss_tready, data_addr}, {1'b1, 4'd1});
        for (int i = 0; i < 7; i++) begin
            chk("idle_in", {ss_tready, data_we, pe_cal, pe_acc_on,
                            sm_tvalid, tap_addr}, {5'b10000, 4'd0});
            @(negedge clk);
        end
        send(4);
        ss_tvalid = 1'b1;
        #1;
        chk("mac_ign", {ss_tready, data_we}, 0);
        @(negedge clk);
        ss_tvalid = 1'b0;
        wait_done();

        // async reset mid-MAC, then restart
        taps[0] = 1; taps[1] = 1; taps[2] = 1; taps[3] = 1;
        start_job(4, 3);
        send(9);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out", {ap_idle, ap_done, ss_tready, sm_tvalid,
                         data_we, pe_cal, pe_acc_on, pe_last},
            8'b10000000);
        chk("arst_addr", {tap_addr, data_addr}, 0);
        exp_y.delete();
        exp_last.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst", {ap_idle, ap_done}, 2'b10);
            @(negedge clk);
        end
        taps[0] = 1; taps[1] = 2; taps[2] = 3;
        start_job(3, 1);
        chk("restart_clr", {data_we, data_wsel, data_addr},
            {1'b1, 1'b0, 4'd0});
        send(5);
        wait_done();

        chk("sb_empty", exp_y.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
